// File: rtl/nibble_serial_adder.sv
// Wide add/subtract sequenced one nibble per clock through a single shared
// 4-bit ripple adder; result, carry-out and signed overflow land at done.

module fulladder4a (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] so,
  output logic       co
);

  always_comb begin
    logic c;
    c  = ci;
    so = '0;
    for (int i = 0; i < 4; i++) begin
      so[i] = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_so;
  logic          nib_co;
  logic          accept;
  logic          last;

  assign accept = start && (state != RUN);
  assign last   = (idx == IW'(NIBBLES - 1));

  // Outside RUN the index may point past the operands; the shift then yields zero.
  assign nib_a = 4'(a_reg >> {idx, 2'b00});
  assign nib_b = 4'(b_reg >> {idx, 2'b00});

  fulladder4a u_add (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .so (nib_so),
    .co (nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the inversion and forced carry happen at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_reg <= op_a;
      b_reg <= sub ? ~op_b : op_b;
      carry <= sub | cin;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (idx == IW'(n)) sum[4*n +: 4] <= nib_so;
      end
      carry <= nib_co;
      idx   <= idx + IW'(1);
      if (last) begin
        cout <= nib_co;
        ovf  <= (a_reg[W-1] == b_reg[W-1]) && (nib_so[3] != a_reg[W-1]);
      end
    end
  end

endmodule
